// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, complex packing and FP arithmetic helpers
package fft_pkg;
    localparam int FLOAT_LEN      = 32;
    localparam int CPLX_LEN       = 2 * FLOAT_LEN;
    localparam int RE_MSB         = 63;
    localparam int RE_LSB         = 32;
    localparam int IM_MSB         = 31;
    localparam int IM_LSB         = 0;
    localparam int TF_LAT         = 1;
    localparam int MUL_LAT        = 6;
    localparam int ADD_LAT        = 11;
    localparam int N_POINTS       = 8192;
    localparam int FRAME_ADDR_LEN = 13;

    typedef logic [FLOAT_LEN-1:0] float_t;
    typedef struct packed { float_t re; float_t im; } cplx_t;
    typedef struct packed { float_t ac; float_t bd; float_t ad; float_t bc; } prod_t;

    // Single-precision multiply: round-to-nearest-even, denormals flushed to zero.
    function automatic float_t fp_mul(input float_t x, input float_t y);
        logic [47:0]        p;
        logic [23:0]        m;
        logic               s, g, st, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        logic signed [10:0] e;
        float_t             r;
        s      = x[31] ^ y[31];
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = $signed({3'b000, x[30:23]}) + $signed({3'b000, y[30:23]}) - 11'sd127;
        if (p[47]) begin
            m  = {1'b0, p[46:24]};
            g  = p[23];
            st = |p[22:0];
            e  = e + 11'sd1;
        end else begin
            m  = {1'b0, p[45:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) begin
            m = 24'd0;
            e = e + 11'sd1;
        end
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) r = 32'h7FC0_0000;
        else if (x_inf || y_inf)                                      r = {s, 8'hFF, 23'd0};
        else if (x_zero || y_zero)                                    r = {s, 31'd0};
        else if (e >= 11'sd255)                                       r = {s, 8'hFF, 23'd0};
        else if (e <= 11'sd0)                                         r = {s, 31'd0};
        else                                                          r = {s, e[7:0], m[22:0]};
        return r;
    endfunction

    // Single-precision add with 3 guard/round/sticky bits; subtract by flipping y's sign.
    function automatic float_t fp_add(input float_t x, input float_t y);
        float_t             big, sml, r;
        logic [7:0]         d;
        logic [26:0]        ma, mb, mask, n;
        logic [27:0]        s;
        logic [23:0]        m;
        logic [4:0]         lz;
        logic               found, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        logic signed [10:0] e;
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        if (x[30:0] < y[30:0]) begin
            big = y;
            sml = x;
        end else begin
            big = x;
            sml = y;
        end
        d    = big[30:23] - sml[30:23];
        ma   = {1'b1, big[22:0], 3'b000};
        mb   = {1'b1, sml[22:0], 3'b000};
        mask = '0;
        if (d > 8'd26) begin
            mb = 27'd1;
        end else begin
            mask = (27'd1 << d) - 27'd1;
            mb   = (mb >> d) | {26'd0, |(mb & mask)};
        end
        s = (big[31] == sml[31]) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
        e     = $signed({3'b000, big[30:23]});
        lz    = 5'd0;
        found = 1'b0;
        if (s[27]) begin
            n = s[27:1] | {26'd0, s[0]};
            e = e + 11'sd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (s[i]) found = 1'b1;
                    else      lz    = lz + 5'd1;
                end
            end
            n = s[26:0] << lz;
            e = e - $signed({6'd0, lz});
        end
        m = {1'b0, n[25:3]};
        if (n[2] && ((|n[1:0]) || m[0])) m = m + 24'd1;
        if (m[23]) begin
            m = 24'd0;
            e = e + 11'sd1;
        end
        if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) r = 32'h7FC0_0000;
        else if (x_inf)               r = x;
        else if (y_inf)               r = y;
        else if (x_zero && y_zero)    r = {x[31] & y[31], 31'd0};
        else if (x_zero)              r = y;
        else if (y_zero)              r = x;
        else if (!n[26])              r = 32'd0;
        else if (e >= 11'sd255)       r = {big[31], 8'hFF, 23'd0};
        else if (e <= 11'sd0)         r = {big[31], 31'd0};
        else                          r = {big[31], e[7:0], m[22:0]};
        return r;
    endfunction
endpackage

// File: rtl/fp_cmul.sv
// rtl/fp_cmul.sv - pipelined single-precision complex multiply with valid/last delay line
module fp_cmul
    import fft_pkg::*;
#(
    parameter int MUL_STAGES = MUL_LAT,
    parameter int ADD_STAGES = ADD_LAT
) (
    input  logic  clk,
    input  logic  rst,
    input  cplx_t a,
    input  cplx_t b,
    input  logic  in_valid,
    input  logic  in_last,
    output cplx_t out,
    output logic  out_valid,
    output logic  out_last
);
    localparam int DEPTH = MUL_STAGES + ADD_STAGES;

    prod_t            w_prod;
    cplx_t            w_sum;
    prod_t            r_mul [MUL_STAGES];
    cplx_t            r_add [ADD_STAGES];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_lst;

    always_comb begin
        w_prod.ac = fp_mul(a.re, b.re);
        w_prod.bd = fp_mul(a.im, b.im);
        w_prod.ad = fp_mul(a.re, b.im);
        w_prod.bc = fp_mul(a.im, b.re);
    end

    always_comb begin
        w_sum.re = fp_add(r_mul[MUL_STAGES-1].ac, {~r_mul[MUL_STAGES-1].bd[31], r_mul[MUL_STAGES-1].bd[30:0]});
        w_sum.im = fp_add(r_mul[MUL_STAGES-1].ad, r_mul[MUL_STAGES-1].bc);
    end

    // Arithmetic stages run free; only the final stage is gated so the output holds between samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) r_mul[i] <= '0;
            for (int i = 0; i < ADD_STAGES; i++) r_add[i] <= '0;
            r_vld <= '0;
            r_lst <= '0;
        end else begin
            r_mul[0] <= w_prod;
            for (int i = 1; i < MUL_STAGES; i++) r_mul[i] <= r_mul[i-1];
            r_add[0] <= w_sum;
            for (int i = 1; i < ADD_STAGES - 1; i++) r_add[i] <= r_add[i-1];
            if (r_vld[DEPTH-2]) r_add[ADD_STAGES-1] <= r_add[ADD_STAGES-2];
            r_vld <= {r_vld[DEPTH-2:0], in_valid};
            r_lst <= {r_lst[DEPTH-2:0], in_valid & in_last};
        end
    end

    assign out       = r_add[ADD_STAGES-1];
    assign out_valid = r_vld[DEPTH-1];
    assign out_last  = r_lst[DEPTH-1];
endmodule

// File: rtl/tf_cmul_stage6.sv
// rtl/tf_cmul_stage6.sv - stage-6 twiddle consumer: aligns samples to the provider and multiplies
module tf_cmul_stage6 #(
    parameter int FLOAT_LEN      = fft_pkg::FLOAT_LEN,
    parameter int FRAME_ADDR_LEN = fft_pkg::FRAME_ADDR_LEN,
    parameter int TF_LAT         = fft_pkg::TF_LAT,
    parameter int MUL_LAT        = fft_pkg::MUL_LAT,
    parameter int ADD_LAT        = fft_pkg::ADD_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*FLOAT_LEN-1:0] din,
    input  logic                   din_valid,
    output logic                   tf_en,
    input  logic [2*FLOAT_LEN-1:0] tf_data,
    input  logic                   tf_valid,
    output logic [2*FLOAT_LEN-1:0] dout,
    output logic                   dout_valid,
    output logic                   dout_last,
    output logic                   align_err
);
    logic [2*FLOAT_LEN-1:0]  r_din_d [TF_LAT];
    logic [TF_LAT-1:0]       r_dv_d;
    logic [TF_LAT-1:0]       r_dl_d;
    logic [FRAME_ADDR_LEN-1:0] r_cnt;
    logic                    r_align_err;
    logic                    w_last;

    // One provider address step per accepted sample keeps twiddle index locked to sample index.
    assign tf_en  = din_valid;
    assign w_last = din_valid && (r_cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TF_LAT; i++) r_din_d[i] <= '0;
            r_dv_d      <= '0;
            r_dl_d      <= '0;
            r_cnt       <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_din_d[0] <= din;
            r_dv_d[0]  <= din_valid;
            r_dl_d[0]  <= w_last;
            for (int i = 1; i < TF_LAT; i++) begin
                r_din_d[i] <= r_din_d[i-1];
                r_dv_d[i]  <= r_dv_d[i-1];
                r_dl_d[i]  <= r_dl_d[i-1];
            end
            if (din_valid) r_cnt <= r_cnt + 1'b1;
            if (r_dv_d[TF_LAT-1] != tf_valid) r_align_err <= 1'b1;
        end
    end

    assign align_err = r_align_err;

    fp_cmul #(
        .MUL_STAGES (MUL_LAT),
        .ADD_STAGES (ADD_LAT)
    ) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .a         (r_din_d[TF_LAT-1]),
        .b         (tf_data),
        .in_valid  (r_dv_d[TF_LAT-1]),
        .in_last   (r_dl_d[TF_LAT-1]),
        .out       (dout),
        .out_valid (dout_valid),
        .out_last  (dout_last)
    );
endmodule

// File: tb/tb_tf_cmul_stage6.sv
// tb/tb_tf_cmul_stage6.sv - randomized scoreboard bench for tf_cmul_stage6 with a twiddle provider model
module tb_tf_cmul_stage6;
    localparam int NPTS = 8192;
    localparam int LAT  = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din;
    logic        din_valid;
    logic        tf_en;
    logic [63:0] tf_data;
    logic        tf_valid;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        align_err;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_smp  = 0;

    int          tw_re [32];
    int          tw_im [32];
    logic [4:0]  tw_addr;
    logic        tf_vq;
    logic        tf_kill;

    typedef struct { logic [63:0] data; logic last; int stamp; } exp_t;
    exp_t        sbq [$];
    logic [63:0] held;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tf_cmul_stage6 dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .tf_en      (tf_en),
        .tf_data    (tf_data),
        .tf_valid   (tf_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .align_err  (align_err)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Exact float encoding of num * 2^-shift, for |num| < 2^24.
    function automatic logic [31:0] f32(input int num, input int shift);
        int          mag;
        int          p;
        logic [31:0] mg;
        if (num == 0) return 32'd0;
        mag = (num < 0) ? -num : num;
        p   = 0;
        for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
        mg = mag;
        mg = mg << (23 - p);
        return {num < 0, 8'(127 + p - shift), mg[22:0]};
    endfunction

    function automatic int rnz(input int lim);
        int v;
        v = int'($urandom_range(0, 2 * lim - 1)) - lim;
        if (v >= 0) v++;
        return v;
    endfunction

    // Twiddle provider: registered table read, address advances on tf_en.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tw_addr <= '0;
            tf_vq   <= 1'b0;
            tf_data <= '0;
        end else begin
            tf_vq <= tf_en;
            if (tf_en) begin
                tf_data <= {f32(tw_re[tw_addr], 4), f32(tw_im[tw_addr], 4)};
                tw_addr <= tw_addr + 5'd1;
            end
        end
    end
    assign tf_valid = tf_vq & ~tf_kill;

    always @(negedge clk) begin
        exp_t e;
        check_vec("tf_en", 64'(tf_en), 64'(din_valid));
        if (rst) begin
            held <= '0;
        end else if (dout_valid) begin
            if (sbq.size() == 0) begin
                check_vec("spurious_valid", 64'(dout_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                check_vec("dout", dout, e.data);
                check_vec("last", 64'(dout_last), 64'(e.last));
                check_vec("latency", 64'(cyc), 64'(e.stamp));
            end
            held <= dout;
        end else begin
            check_vec("hold", dout, held);
            check_vec("last_idle", 64'(dout_last), 64'd0);
        end
    end

    task automatic put(input bit v, input int ar, input int ai);
        exp_t e;
        int   k;
        @(posedge clk); #1;
        din_valid = v;
        if (v) begin
            din = {f32(ar, 4), f32(ai, 4)};
            k   = n_smp % 32;
            e.data  = {f32(ar * tw_re[k] - ai * tw_im[k], 8), f32(ar * tw_im[k] + ai * tw_re[k], 8)};
            e.last  = (n_smp % NPTS) == NPTS - 1;
            e.stamp = cyc + LAT;
            sbq.push_back(e);
            n_smp++;
        end else begin
            din = {$urandom, $urandom};
        end
    endtask

    task automatic put_rand(input bit v);
        put(v, rnz(1022), rnz(1022));
    endtask

    task automatic drain();
        put(1'b0, 0, 0);
        for (int i = 0; i < 60 && sbq.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check_vec("drain", 64'(sbq.size()), 64'd0);
    endtask

    task automatic new_table();
        for (int i = 0; i < 32; i++) begin
            tw_re[i] = rnz(16);
            tw_im[i] = rnz(16);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst       = 1'b1;
        din_valid = 1'b1;
        #1;
        check_vec("rst_dout_valid", 64'(dout_valid), 64'd0);
        check_vec("rst_dout_last", 64'(dout_last), 64'd0);
        check_vec("rst_align_err", 64'(align_err), 64'd0);
        check_vec("rst_dout", dout, 64'd0);
        check_vec("rst_tf_en", 64'(tf_en), 64'd1);
        sbq.delete();
        n_smp     = 0;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        tf_kill   = 1'b0;
        held      = '0;
        new_table();
        repeat (3) @(posedge clk);
        #4;
        check_vec("init_dout_valid", 64'(dout_valid), 64'd0);
        check_vec("init_align_err", 64'(align_err), 64'd0);
        check_vec("init_dout", dout, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Identity: (2+3j)*(1+0j), then (1+2j)*(3+4j) on the next twiddle index.
        tw_re[0] = 16; tw_im[0] = 0;
        tw_re[1] = 48; tw_im[1] = 64;
        put(1'b1, 32, 48);
        drain();
        check_vec("identity", dout, 64'h4000_0000_4040_0000);
        put(1'b1, 16, 32);
        drain();
        check_vec("product", dout, 64'hC0A0_0000_4120_0000);

        // Gapped pattern from a fresh frame.
        new_table();
        do_reset();
        foreach (tw_re[i]) if (i < 0) $display("unused");
        put_rand(1'b1); put_rand(1'b0); put_rand(1'b0); put_rand(1'b1);
        put_rand(1'b1); put_rand(1'b0); put_rand(1'b1);
        drain();
        check_vec("gap_align_err", 64'(align_err), 64'd0);

        // Misalignment: drop tf_valid while the delayed sample is valid.
        put_rand(1'b1);
        @(posedge clk); #1;
        din_valid = 1'b0;
        tf_kill   = 1'b1;
        @(negedge clk);
        check_vec("align_pre", 64'(align_err), 64'd0);
        @(posedge clk); #1;
        tf_kill = 1'b0;
        check_vec("align_set", 64'(align_err), 64'd1);
        drain();
        check_vec("align_hold", 64'(align_err), 64'd1);

        // Random gapped stream, reset while samples are in flight.
        for (int i = 0; i < 200; i++) put_rand($urandom_range(0, 3) != 0);
        do_reset();
        check_vec("post_rst_align", 64'(align_err), 64'd0);

        // Full frame plus a few samples: last only on index 8191, 8192 wraps to twiddle 0.
        new_table();
        for (int i = 0; i < NPTS + 5; i++) put_rand(1'b1);
        drain();
        check_vec("frame_align", 64'(align_err), 64'd0);

        for (int i = 0; i < 300; i++) put_rand($urandom_range(0, 1) != 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
